mem_link_arbiter: RTL
=====================

# mem_link_arbiter

CPU-side controller for the 72-bit message link that carries all memory traffic to the UART-attached memory. Two requesters share the link: instruction fetch (read-only) and data (load/store with byte mask). The block arbitrates between them, packs each request into a link message, sequences send → response → completion with exactly one transaction outstanding, and flags protocol errors and response timeouts.

## Interface
- `TIMEOUT`, default 1048576: cycles allowed in WAIT_RESP before abort; 0 disables the watchdog.
- `CNT_W`, default 24: width of the watchdog counter; must satisfy 2^CNT_W > TIMEOUT.

- `clk` in 1: single clock; everything is on its rising edge.
- `RST_N` in 1: asynchronous, active-low reset.
- `if_req` in 1: fetch request; held with `if_addr` until `if_done`.
- `if_addr` in 32: fetch byte address.
- `if_done` out 1: one-cycle completion pulse.
- `if_rdata` out 32: fetched word; valid while `if_done`=1.
- `d_req` in 1: data request; held with its fields until `d_done`.
- `d_we` in 1: 1 = store, 0 = load.
- `d_addr` in 32: data byte address.
- `d_wdata` in 32: store data.
- `d_mask` in 4: store byte enables; bit i enables `d_wdata[8i+7:8i]`.
- `d_done` out 1: one-cycle completion pulse.
- `d_rdata` out 32: load data; valid while `d_done`=1.
- `link_write_flag` out 1: pushes one message into the link.
- `link_write_length` out 5: message length in bytes.
- `link_write_data` out 72: message payload.
- `link_writable` in 1: link can accept a message this cycle.
- `link_read_flag` out 1: pops the head response.
- `link_read_length` in 5: head response length.
- `link_read_data` in 72: head response payload.
- `link_readable` in 1: a response is available.
- `link_err` out 1: sticky error; cleared only by reset.

## Operation
- Message formats:
  - Read: length 5, `data[31:0]`=addr, `data[32]`=0, all other bits 0.
  - Write: length 9, `data[31:0]`=wdata, `data[63:32]`=addr, `data[67:64]`=mask, `data[71:68]`=0.
  - Response: length 4, `data[31:0]`=word.
- Stores send a write message and expect no response.
- States:
  - IDLE: if any `*_req`, grant, latch all request fields, go to SEND.
  - SEND: `link_write_flag` = `link_writable` (combinational). When the flag fires, a store goes to DONE and a load/fetch goes to WAIT_RESP.
  - WAIT_RESP: `link_read_flag` = `link_readable`. On a pop:
    - length 4: capture `data[31:0]`, go to DONE.
    - any other length: discard it, set `link_err`, stay in WAIT_RESP.
  - DONE: pulse the granted requester's `*_done` for one cycle, update `last_grant`, go to IDLE.
- Arbitration:
  - Only one requester active: grant it.
  - Both active: grant the one not equal to `last_grant`.
  - `last_grant` resets to "fetch", so data wins the first tie.
- Watchdog:
  - Counter clears on entry to WAIT_RESP and increments each cycle there.
  - Reaching `TIMEOUT` sets `link_err` and goes to DONE with `rdata`=0.
- A response present in IDLE or SEND is popped (in IDLE only), discarded, and sets `link_err`.
- A requester keeping `*_req` high through `*_done` issues a new request, arbitrated in the following IDLE cycle.

## Timing
- Reset values: state IDLE; all `*_done`, `*_rdata`, `link_write_*`, `link_read_flag` and `link_err` are 0; counter 0.
- Store, writable: req seen cycle 0 → flag cycle 1 → done cycle 2. Latency 2 cycles; one transaction every 3 cycles.
- Load/fetch: flag at cycle 1 → pop at cycle k (first cycle readable, k ≥ 2) → done at cycle k+1.
- `link_write_data` and `link_write_length` are driven from latched registers, stable for all of SEND. They are 0 outside SEND.
- Requester inputs are sampled only in IDLE. Changes after grant are ignored.
- Reset mid-transaction aborts immediately with no `done`. A late response then arrives in IDLE and is flagged as an error; this is accepted behaviour.

## Structure
- Package `mem_link_pkg` holds:
  - `LEN_READ`=5, `LEN_WRITE`=9, `LEN_RESP`=4;
  - field bit positions (`ADDR_LO`=32, `MASK_LO`=64);
  - the state enum {IDLE, SEND, WAIT_RESP, DONE};
  - the grant enum {G_IF, G_D}.
- Sub-module `mem_link_pack`: combinational (we, addr, wdata, mask) → (length, data). Reused by future requesters.

## Test plan
- Fetch `if_addr`=0x100, memory returns 0x00000013 → `link_write_data`=0x100 with length 5, `if_done` with `if_rdata`=0x13 one cycle after the pop.
- Store `d_addr`=0x104, `d_wdata`=0x41, `d_mask`=0001 → one message, length 9, `data[67:64]`=1, `data[63:32]`=0x104; `d_done` at cycle 2; no pop.
- `if_req` and `d_req` both held high for 4 transactions → grants D, IF, D, IF.
- `link_writable` low for 5 cycles in SEND → flag held off, then a single push; payload stable throughout.
- Response with length 9 in WAIT_RESP → popped, `link_err`=1, still waiting; a following length-4 response completes normally.
- `TIMEOUT`=16, no response → `link_err`=1 and `if_done` with `if_rdata`=0 at cycle 16 after WAIT_RESP entry; `RST_N` low clears `link_err` asynchronously.

Source files
------------

// File: rtl/mem_link_pkg.sv
// Shared types and message-format constants for the CPU memory link.
package mem_link_pkg;

  localparam logic [4:0] LEN_READ  = 5'd5;
  localparam logic [4:0] LEN_WRITE = 5'd9;
  localparam logic [4:0] LEN_RESP  = 5'd4;

  localparam int ADDR_LO = 32;
  localparam int MASK_LO = 64;

  typedef enum logic [1:0] {IDLE, SEND, WAIT_RESP, DONE} state_e;
  typedef enum logic {G_IF, G_D} grant_e;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
  } req_t;

endpackage

// File: rtl/mem_link_pack.sv
// Packs one requester transaction into a link message (length + 72-bit payload).
module mem_link_pack
  import mem_link_pkg::*;
(
  input  req_t        req,
  output logic [4:0]  length,
  output logic [71:0] data
);

  always_comb begin
    length = LEN_READ;
    data   = '0;
    if (req.we) begin
      length              = LEN_WRITE;
      data[31:0]          = req.wdata;
      data[ADDR_LO +: 32] = req.addr;
      data[MASK_LO +: 4]  = req.mask;
    end else begin
      data[31:0] = req.addr;
    end
  end

endmodule

// File: rtl/mem_link_arbiter.sv
// Two-requester (fetch / data) front end for the memory message link with
// one transaction in flight, response checking and a response watchdog.
module mem_link_arbiter
  import mem_link_pkg::*;
#(
  parameter int TIMEOUT = 1048576,
  parameter int CNT_W   = 24
) (
  input  logic        clk,
  input  logic        RST_N,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_mask,
  output logic        d_done,
  output logic [31:0] d_rdata,
  output logic        link_write_flag,
  output logic [4:0]  link_write_length,
  output logic [71:0] link_write_data,
  input  logic        link_writable,
  output logic        link_read_flag,
  input  logic [4:0]  link_read_length,
  input  logic [71:0] link_read_data,
  input  logic        link_readable,
  output logic        link_err
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e            state_q, state_d;
  grant_e            grant_q, last_grant_q, grant_sel;
  req_t              req_q, req_sel;
  logic [CNT_W-1:0]  cnt_q;
  logic [31:0]       rdata_q;
  logic              err_q;
  logic [4:0]        pk_len;
  logic [71:0]       pk_data;
  logic              any_req, wr_fire, rd_pop, resp_ok, tmo;
  logic              unused_resp_hi;

  assign unused_resp_hi = ^link_read_data[71:32];

  mem_link_pack u_pack (
    .req    (req_q),
    .length (pk_len),
    .data   (pk_data)
  );

  // Tie goes to whoever was not served last.
  always_comb begin
    any_req   = if_req | d_req;
    grant_sel = G_IF;
    if (if_req && d_req)
      grant_sel = (last_grant_q == G_IF) ? G_D : G_IF;
    else if (d_req)
      grant_sel = G_D;
    req_sel.we    = 1'b0;
    req_sel.addr  = if_addr;
    req_sel.wdata = '0;
    req_sel.mask  = '0;
    if (grant_sel == G_D) begin
      req_sel.we    = d_we;
      req_sel.addr  = d_addr;
      req_sel.wdata = d_wdata;
      req_sel.mask  = d_mask;
    end
    wr_fire = (state_q == SEND) && link_writable;
    rd_pop  = ((state_q == IDLE) || (state_q == WAIT_RESP)) && link_readable;
    resp_ok = (state_q == WAIT_RESP) && rd_pop && (link_read_length == LEN_RESP);
    tmo     = (TIMEOUT != 0) && (state_q == WAIT_RESP) && !resp_ok && (cnt_q == CNT_LAST);
  end

  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (any_req) state_d = SEND;
      SEND:      if (wr_fire) state_d = req_q.we ? DONE : WAIT_RESP;
      WAIT_RESP: if (resp_ok || tmo) state_d = DONE;
      DONE:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    link_write_flag   = wr_fire;
    link_write_length = (state_q == SEND) ? pk_len  : '0;
    link_write_data   = (state_q == SEND) ? pk_data : '0;
    link_read_flag    = rd_pop;
    if_done           = (state_q == DONE) && (grant_q == G_IF);
    d_done            = (state_q == DONE) && (grant_q == G_D);
    if_rdata          = if_done ? rdata_q : '0;
    d_rdata           = d_done  ? rdata_q : '0;
    link_err          = err_q;
  end

  // rdata is cleared at grant so a watchdog abort completes with zero.
  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      grant_q      <= G_IF;
      last_grant_q <= G_IF;
      req_q        <= '0;
      cnt_q        <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (any_req) begin
          grant_q <= grant_sel;
          req_q   <= req_sel;
          rdata_q <= '0;
        end
        SEND: if (wr_fire) cnt_q <= '0;
        WAIT_RESP: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (resp_ok) rdata_q <= link_read_data[31:0];
        end
        DONE:    last_grant_q <= grant_q;
        default: ;
      endcase
      // Unsolicited or malformed responses and watchdog expiry are sticky errors.
      if ((rd_pop && !resp_ok) || ((state_q == SEND) && link_readable) || tmo)
        err_q <= 1'b1;
    end
  end

endmodule
